// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 slave register file in front of uart_core.
// Holds divisor/config, turns DATA accesses into TX push / RX pop strobes,
// and keeps sticky error status (parity, TX overflow, RX underflow).
// Optional feature macro: UART_IRQ_EN (interrupt enables in CFG[6:4], o_irq).
//
// state | meaning
// IDLE  | no transfer in progress
// SETUP | APB setup phase seen, waiting for the access phase
// ACK   | o_pready high, all side effects of the transfer take place
module uart_apb_regs #(
  parameter logic [15:0] DIV_RESET = 16'd325,
  parameter logic [7:0]  CFG_RESET = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [3:0]  i_paddr,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  output logic [15:0] o_divisor,
  output logic [1:0]  o_num_bit_data,
  output logic        o_parity_en,
  output logic        o_parity_type,
  output logic [7:0]  o_cpu_txd,
  output logic        o_tx_wr,
  input  logic        i_tx_full,
  input  logic [7:0]  i_cpu_rxd,
  output logic        o_rx_rd,
  input  logic        i_rx_empty,
  input  logic        i_parity_err,
  output logic        o_irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACK} state_t;

  state_t      state, state_next;
  logic [3:0]  cfg;
  logic [2:0]  ie;
  logic        par_err, tx_ovf, rx_udf;
  logic        access;
  logic        err, push, pop, div_we, cfg_we, w1c, set_ovf, set_udf;
  logic [31:0] rdata_next;
  logic        unused_pwdata;

  assign unused_pwdata = ^i_pwdata[31:16];
  assign {o_parity_type, o_parity_en, o_num_bit_data} = cfg;
  // Decisions are taken on the SETUP->ACK edge so their effects are visible in ACK.
  assign access = (state == SETUP) && i_psel && i_penable;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_psel && !i_penable) state_next = SETUP;
      SETUP:   state_next = (i_psel && i_penable) ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address decode and per-transfer response for the access about to be acknowledged.
  always_comb begin
    err        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    div_we     = 1'b0;
    cfg_we     = 1'b0;
    w1c        = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    rdata_next = 32'd0;
    if (access) begin
      if (i_paddr[1:0] != 2'b00) begin
        err = 1'b1;
      end else begin
        case (i_paddr[3:2])
          2'd0: begin
            if (i_pwrite) begin
              if (i_tx_full) begin err = 1'b1; set_ovf = 1'b1; end
              else push = 1'b1;
            end else begin
              if (i_rx_empty) begin err = 1'b1; set_udf = 1'b1; end
              else begin pop = 1'b1; rdata_next = {24'd0, i_cpu_rxd}; end
            end
          end
          2'd1: begin
            if (i_pwrite) begin
              if (i_pwdata[15:0] == 16'd0) err = 1'b1;
              else div_we = 1'b1;
            end else rdata_next = {16'd0, o_divisor};
          end
          2'd2: begin
            if (i_pwrite) cfg_we = 1'b1;
            else rdata_next = {25'd0, ie, cfg};
          end
          default: begin
            if (i_pwrite) w1c = 1'b1;
            else rdata_next = {27'd0, rx_udf, tx_ovf, par_err, i_rx_empty, i_tx_full};
          end
        endcase
      end
    end
  end

  // Bus response, FIFO strobes, config and sticky status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= 32'd0;
      o_tx_wr   <= 1'b0;
      o_rx_rd   <= 1'b0;
      o_cpu_txd <= 8'd0;
      o_divisor <= DIV_RESET;
      cfg       <= CFG_RESET[3:0];
      par_err   <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_udf    <= 1'b0;
    end else begin
      o_pready  <= access;
      o_pslverr <= err;
      o_prdata  <= rdata_next;
      o_tx_wr   <= push;
      o_rx_rd   <= pop;
      if (push)   o_cpu_txd <= i_pwdata[7:0];
      if (div_we) o_divisor <= i_pwdata[15:0];
      if (cfg_we) cfg       <= i_pwdata[3:0];
      // A new parity error in the same cycle as its W1C wins.
      par_err <= i_parity_err | (par_err & ~(w1c & i_pwdata[2]));
      tx_ovf  <= set_ovf      | (tx_ovf  & ~(w1c & i_pwdata[3]));
      rx_udf  <= set_udf      | (rx_udf  & ~(w1c & i_pwdata[4]));
    end
  end

`ifdef UART_IRQ_EN
  // Interrupt enables and registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie    <= 3'd0;
      o_irq <= 1'b0;
    end else begin
      if (cfg_we) ie <= i_pwdata[6:4];
      o_irq <= (ie[0] & ~i_rx_empty) | (ie[1] & ~i_tx_full) |
               (ie[2] & (par_err | tx_ovf | rx_udf));
    end
  end
`else
  assign ie    = 3'd0;
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_apb_regs.sv
// Self-checking bench for uart_apb_regs: vector table of APB transfers with a
// response scoreboard, plus hand sequences for sticky parity, IRQ and reset.
module tb_uart_apb_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = 4'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] divisor;
  logic [1:0]  num_bit_data;
  logic        parity_en, parity_type;
  logic [7:0]  cpu_txd;
  logic        tx_wr, rx_rd, irq;
  logic        tx_full = 1'b0, rx_empty = 1'b1, parity_err = 1'b0;
  logic [7:0]  cpu_rxd = 8'd0;

  int errors = 0;
  int checks = 0;

`ifdef UART_IRQ_EN
  localparam logic [31:0] CFG_RB = 32'h7E;
  localparam logic        IRQ_ON = 1'b1;
`else
  localparam logic [31:0] CFG_RB = 32'h0E;
  localparam logic        IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
    logic        txwr;
    logic        rxrd;
    logic [7:0]  txd;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        full;
    logic        empty;
    logic [7:0]  rxd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  uart_apb_regs dut (
    .clk(clk), .rst(rst),
    .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_divisor(divisor), .o_num_bit_data(num_bit_data),
    .o_parity_en(parity_en), .o_parity_type(parity_type),
    .o_cpu_txd(cpu_txd), .o_tx_wr(tx_wr), .i_tx_full(tx_full),
    .i_cpu_rxd(cpu_rxd), .o_rx_rd(rx_rd), .i_rx_empty(rx_empty),
    .i_parity_err(parity_err), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic chk_rd, input logic [31:0] rdata, input logic err,
                              input logic txwr, input logic rxrd, input logic [7:0] txd);
    exp_t e;
    e.chk_rd = chk_rd; e.rdata = rdata; e.err = err;
    e.txwr = txwr; e.rxrd = rxrd; e.txd = txd;
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                              input logic full, input logic empty, input logic [7:0] rxd,
                              input exp_t e);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.full = full; v.empty = empty; v.rxd = rxd; v.e = e;
    return v;
  endfunction

  // Response monitor: pops the scoreboard on every acknowledged transfer and
  // checks that the FIFO strobes never fire outside an acknowledge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", 32'(pready), 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.chk_rd) chk("prdata", prdata, e.rdata);
          chk("pslverr", 32'(pslverr), 32'(e.err));
          chk("tx_wr", 32'(tx_wr), 32'(e.txwr));
          chk("rx_rd", 32'(rx_rd), 32'(e.rxrd));
          if (e.txwr) chk("cpu_txd", 32'(cpu_txd), 32'(e.txd));
        end
      end else begin
        chk("strobe_outside_ack", 32'({tx_wr, rx_rd}), 32'd0);
      end
    end
  end

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d, input exp_t e);
    int n;
    sb.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    @(negedge clk);
    while (!pready && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("pready_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // wr addr wdata full empty rxd | chk_rd rdata err txwr rxrd txd
    vecs.push_back(mk(0, 4'h4, 0,        0, 1, 8'h00, ex(1, 32'd325, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h8, 0,        0, 1, 8'h00, ex(1, 32'h03,  0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h0, 32'hA5,   0, 1, 8'h00, ex(0, 0,       0, 1, 0, 8'hA5)));
    vecs.push_back(mk(1, 4'h0, 32'h5A,   1, 1, 8'h00, ex(0, 0,       1, 0, 0, 0)));
    vecs.push_back(mk(0, 4'hC, 0,        1, 0, 8'h00, ex(1, 32'h09,  0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'hC, 32'h08,   1, 0, 8'h00, ex(0, 0,       0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'hC, 0,        1, 0, 8'h00, ex(1, 32'h01,  0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h0, 0,        0, 0, 8'h3C, ex(1, 32'h3C,  0, 0, 1, 0)));
    vecs.push_back(mk(0, 4'h0, 0,        0, 1, 8'h3C, ex(1, 32'h00,  1, 0, 0, 0)));
    vecs.push_back(mk(0, 4'hC, 0,        0, 1, 8'h00, ex(1, 32'h12,  0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'hC, 32'h13,   0, 1, 8'h00, ex(0, 0,       0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'hC, 0,        0, 1, 8'h00, ex(1, 32'h02,  0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h4, 0,        0, 1, 8'h00, ex(0, 0,       1, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h4, 0,        0, 1, 8'h00, ex(1, 32'd325, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h4, 32'h1234, 0, 1, 8'h00, ex(0, 0,       0, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h5, 32'hFFFF, 0, 1, 8'h00, ex(0, 0,       1, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h4, 0,        0, 1, 8'h00, ex(1, 32'h1234, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h6, 0,        0, 0, 8'h77, ex(1, 32'h00,  1, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h1, 32'hAB,   0, 1, 8'h00, ex(0, 0,       1, 0, 0, 0)));
    vecs.push_back(mk(1, 4'h8, 32'h7E,   0, 1, 8'h00, ex(0, 0,       0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'h8, 0,        0, 1, 8'h00, ex(1, CFG_RB,  0, 0, 0, 0)));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_divisor", 32'(divisor), 32'd325);
    chk("rst_cfg", 32'({parity_type, parity_en, num_bit_data}), 32'h3);
    chk("rst_strobes", 32'({tx_wr, rx_rd, pslverr}), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    foreach (vecs[i]) begin
      tx_full = vecs[i].full; rx_empty = vecs[i].empty; cpu_rxd = vecs[i].rxd;
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].e);
      if (vecs[i].wr && vecs[i].addr == 4'h4) chk("divisor_out", 32'(divisor),
          (vecs[i].wdata == 0) ? 32'd325 : vecs[i].wdata);
    end
    chk("cfg_outputs", 32'({parity_type, parity_en, num_bit_data}), 32'hE);

    // Sticky parity error, including set winning over a simultaneous W1C.
    tx_full = 1'b0; rx_empty = 1'b1;
    @(posedge clk); #1 parity_err = 1'b1;
    @(posedge clk); #1 parity_err = 1'b0;
    apb(0, 4'hC, 0, ex(1, 32'h06, 0, 0, 0, 0));
    parity_err = 1'b1;
    apb(1, 4'hC, 32'h04, ex(0, 0, 0, 0, 0, 0));
    parity_err = 1'b0;
    apb(0, 4'hC, 0, ex(1, 32'h06, 0, 0, 0, 0));
    apb(1, 4'hC, 32'h04, ex(0, 0, 0, 0, 0, 0));
    apb(0, 4'hC, 0, ex(1, 32'h02, 0, 0, 0, 0));

    // Interrupt on RX data available.
    apb(1, 4'h8, 32'h13, ex(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("irq_idle", 32'(irq), 32'd0);
    @(posedge clk); #1 rx_empty = 1'b0;
    @(negedge clk);
    chk("irq_before_edge", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_rx_avail", 32'(irq), 32'(IRQ_ON));
    @(posedge clk); #1 rx_empty = 1'b1;

    // Reset in the middle of an acknowledged DATA write.
    apb(1, 4'h4, 32'h55, ex(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h77;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    chk("mid_tx_wr", 32'(tx_wr), 32'd1);
    chk("mid_cpu_txd", 32'(cpu_txd), 32'h77);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", 32'({pready, tx_wr}), 32'd0);
    chk("rst_mid_divisor", 32'(divisor), 32'd325);
    chk("rst_mid_cfg", 32'({parity_type, parity_en, num_bit_data}), 32'h3);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    apb(0, 4'h4, 0, ex(1, 32'd325, 0, 0, 0, 0));
    apb(0, 4'hC, 0, ex(1, 32'h02, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
